// File: rtl/ifmaps_row_loader.sv
// Unpacks a 32-bit stream of 5-bit ifmap elements into MAC_NUM-element rows held in a FWFT row FIFO.
// Optional IFMAPS_LOADER_LEVEL_EN adds fifo_level and almost_full outputs.
module ifmaps_row_loader #(
    parameter int MAC_NUM = 256,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            row_count,
    output logic                   busy,
    output logic                   done,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [5*MAC_NUM-1:0]   ifmaps_out,
    output logic                   ifmaps_valid,
    input  logic                   ifmaps_pop
`ifdef IFMAPS_LOADER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   almost_full
`endif
);

    localparam int WPR = (MAC_NUM + 5) / 6;
    localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int RW  = 5 * MAC_NUM;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_PUSH,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [WCW-1:0] r_word_cnt;
    logic [15:0]    r_rows_left;
    logic [RW-1:0]  r_row;
    logic [RW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic w_xfer;
    logic w_last_word;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_unused_bits;

    // Bits [31:30] carry no element.
    assign w_unused_bits = ^s_data[31:30];

    assign w_xfer      = s_valid && s_ready;
    assign w_last_word = (r_word_cnt == WCW'(WPR - 1));
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_push      = (r_state == S_PUSH) && !w_full;
    assign w_pop       = ifmaps_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (row_count != 16'd0) ? S_FILL : S_DONE;
                end
            end
            S_FILL: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_xfer && w_last_word) begin
                    w_next = S_PUSH;
                end
            end
            S_PUSH: begin
                busy = 1'b1;
                if (!w_full) begin
                    w_next = (r_rows_left == 16'd1) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Each word lands on elements 6j..6j+5; elements past MAC_NUM are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt  <= '0;
            r_rows_left <= '0;
            r_row       <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_rows_left <= row_count;
                r_word_cnt  <= '0;
            end
            if (w_xfer) begin
                for (int e = 0; e < MAC_NUM; e++) begin
                    if (r_word_cnt == WCW'(e / 6)) begin
                        r_row[5*e +: 5] <= s_data[5*(e%6) +: 5];
                    end
                end
                if (!w_last_word) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
            if (w_push) begin
                r_rows_left <= r_rows_left - 16'd1;
                r_word_cnt  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ifmaps_valid = (r_count != '0);
    assign ifmaps_out   = ifmaps_valid ? r_mem[r_rptr] : '0;

`ifdef IFMAPS_LOADER_LEVEL_EN
    assign fifo_level  = r_count;
    assign almost_full = (r_count >= CW'(DEPTH - 1));
`endif

endmodule
